ising_energy_engine: RTL and testbench
======================================

# ising_energy_engine

Hardware replacement for the software energy check used during annealing. It computes the Ising Hamiltonian H over an N_SPIN spin vector and the lower-triangular coupling memory, processing LANES couplings per cycle. It sits beside the spin-update unit and top controller: the controller pulses `start` after each sweep and reads `energy` on `done`. The bit-packing and sign convention of the coupling rows are the same ones the controller and memory already use.

## Interface
- N_SPIN, 800: spin count; must be ≥2.
- JW, 4: coupling width. Bit JW-1 is the sign, bits JW-2:0 are the magnitude.
- LANES, 8: couplings accumulated per cycle; 1..N_SPIN.
- E_W, 24: signed energy width. Must be ≥ clog2(N_SPIN·(N_SPIN-1)/2·(2^(JW-1)-1))+1. Elaboration fails if it is not.
- clk  in  1: single clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- start  in  1: request one energy evaluation. Honoured only in IDLE.
- spin_vec  in  N_SPIN: spin vector; snapshotted on the accepted start.
- j_rd_en  out  1: coupling-row read strobe.
- j_addr  out  clog2(N_SPIN): row index i.
- j_row_data  in  N_SPIN·JW: row i, with slot j at bits [j·JW +: JW]. Valid exactly 1 cycle after j_rd_en.
- busy  out  1: high from the cycle after the accepted start through FINISH.
- done  out  1: one-cycle pulse in FINISH.
- energy  out  E_W signed: result; held until the next FINISH.

## Operation
- Contribution of pair (i,j), j<i:
  - agree = (s_i==s_j).
  - term = +mag if (agree XNOR sign), otherwise −mag.
  - sign=1 with equal spins adds mag; sign=1 with unequal spins subtracts mag.
  - mag=0 contributes 0 for either sign.
- States and transitions:
  - IDLE: on start, snapshot spin_vec, clear the accumulator, set i=1, go to FETCH.
  - FETCH: j_rd_en=1, j_addr=i, go to WAIT.
  - WAIT: capture j_row_data into the row register, set column base c=0, go to ACC.
  - ACC: add the LANES terms for columns c..c+LANES-1. Lanes with column ≥ i are masked to 0. Then c+=LANES.
    - If c+LANES ≥ i: if i==N_SPIN-1 go to FINISH, otherwise i++ and go to FETCH.
    - Otherwise stay in ACC.
  - FINISH: energy ← accumulator, done=1, go to IDLE.
- Row 0 is never fetched; it has no lower terms.
- The accumulator is E_W-bit two's complement. No saturation is needed, because the width rule guarantees no overflow.
- start while busy is ignored. spin_vec changes after the snapshot have no effect.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, j_rd_en=0, j_addr=0, energy=0.
  - Accumulator and row register are 0.
- Row i costs 2+ceil(i/LANES) cycles.
- Let the accepted start be cycle 0. done is high in cycle L = 1 + Σ_{i=1}^{N_SPIN-1}(2+ceil(i/LANES)). energy is valid from that same cycle.
- A new start is accepted in the cycle after done, i.e. the first IDLE cycle. Back-to-back runs are therefore spaced L+1 cycles apart.
- j_rd_en is high exactly one cycle per row, in FETCH.
- rst asserted mid-run aborts immediately: all outputs return to their reset values and no done is produced.

## Configuration
- ISING_BEST_TRACK_EN defined:
  - Adds outputs best_energy (E_W signed; reset value is the most-positive value) and best_update (1 bit).
  - In FINISH, if the new energy < best_energy: best_energy ← energy and best_update pulses together with done.
  - Ties do not update.
- ISING_BEST_TRACK_EN undefined: these ports and registers do not exist. All other behaviour is identical.

## Test plan
All scenarios use N_SPIN=4, JW=4, LANES=2, giving L=11.
- All couplings 4'b1011 (+3), spins 4'b0000, start → done in cycle 11, energy=+18, one j_rd_en per row 1..3.
- Same couplings, spins 4'b0001 → energy=0. Spins 4'b0101 → energy=−6.
- All couplings 4'b0010 (sign 0, mag 2), spins 4'b1111 → energy=−12. Couplings 4'b1000/4'b0000 (mag 0) → energy=0.
- start pulsed again in cycles 3 and 7 of a run, and spin_vec changed in cycle 2 → single done at cycle 11 with the snapshot result. The next start in cycle 12 is accepted.
- rst asserted in cycle 5 → busy=0 and energy=0 immediately, no done. A fresh start afterwards gives the correct result.
- With ISING_BEST_TRACK_EN, three runs with energies 18, 0, 6 → best_update pulses on runs 1 and 2 only, leaving best_energy=0.

Source files
------------

// File: rtl/ising_energy_engine_if.sv
// Bus between the Ising energy engine, its controller and the coupling memory.
// Optional best-energy tracking ports exist only when ISING_BEST_TRACK_EN is defined.
// master: controller/memory side; slave: the engine.
interface ising_energy_engine_if #(
    parameter int N_SPIN = 800,
    parameter int JW     = 4,
    parameter int E_W    = 24
);
    localparam int AW = $clog2(N_SPIN);

    logic                     start;
    logic [N_SPIN-1:0]        spin_vec;
    logic                     j_rd_en;
    logic [AW-1:0]            j_addr;
    logic [N_SPIN*JW-1:0]     j_row_data;
    logic                     busy;
    logic                     done;
    logic signed [E_W-1:0]    energy;
`ifdef ISING_BEST_TRACK_EN
    logic signed [E_W-1:0]    best_energy;
    logic                     best_update;

    modport master (
        output start, spin_vec, j_row_data,
        input  j_rd_en, j_addr, busy, done, energy, best_energy, best_update
    );
    modport slave (
        input  start, spin_vec, j_row_data,
        output j_rd_en, j_addr, busy, done, energy, best_energy, best_update
    );
`else
    modport master (
        output start, spin_vec, j_row_data,
        input  j_rd_en, j_addr, busy, done, energy
    );
    modport slave (
        input  start, spin_vec, j_row_data,
        output j_rd_en, j_addr, busy, done, energy
    );
`endif
endinterface

// File: rtl/ising_energy_engine.sv
// Ising Hamiltonian evaluator: walks rows 1..N_SPIN-1 of the lower-triangular
// coupling memory, accumulating LANES signed coupling terms per cycle.
// Optional feature macro: ISING_BEST_TRACK_EN (best-energy tracking).
module ising_energy_engine #(
    parameter int N_SPIN = 800,
    parameter int JW     = 4,
    parameter int LANES  = 8,
    parameter int E_W    = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    ising_energy_engine_if.slave  bus
);
    localparam int AW = $clog2(N_SPIN);
    localparam int CW = $clog2(N_SPIN + LANES) + 1;
    localparam logic [63:0] MAX_ABS = 64'(N_SPIN) * 64'(N_SPIN - 1) / 64'd2
                                      * ((64'd1 << (JW - 1)) - 64'd1);
    localparam int EW_MIN = $clog2(MAX_ABS) + 1;

    // Reject configurations that could overflow or are structurally invalid
    generate
        if (N_SPIN < 2) begin : g_bad_nspin
            $error("ising_energy_engine: N_SPIN must be >= 2");
        end
        if (JW < 2) begin : g_bad_jw
            $error("ising_energy_engine: JW must be >= 2");
        end
        if (LANES < 1 || LANES > N_SPIN) begin : g_bad_lanes
            $error("ising_energy_engine: LANES must be in 1..N_SPIN");
        end
        if (E_W < EW_MIN) begin : g_bad_ew
            $error("ising_energy_engine: E_W too narrow for worst-case energy");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_ACC,
        ST_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [N_SPIN-1:0]     spin_q, spin_d;
    logic [N_SPIN*JW-1:0]  row_q, row_d;
    logic [AW-1:0]         i_q, i_d;
    logic [CW-1:0]         c_q, c_d;
    logic signed [E_W-1:0] acc_q, acc_d;
    logic signed [E_W-1:0] energy_q, energy_d;
`ifdef ISING_BEST_TRACK_EN
    logic signed [E_W-1:0] best_q, best_d;
    logic                  best_update_q, best_update_d;
`endif

    logic [CW-1:0]         col;
    logic [JW-1:0]         slot;
    logic                  agree;
    logic                  positive;
    logic signed [E_W-1:0] mag_ext;
    logic signed [E_W-1:0] lane_sum;
    logic signed [E_W-1:0] acc_sum;

    // Sum of this cycle's LANES coupling terms; columns at or above the row index are masked
    always_comb begin
        lane_sum = '0;
        col      = '0;
        slot     = '0;
        agree    = 1'b0;
        positive = 1'b0;
        mag_ext  = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            col = c_q + CW'(k);
            if (col < CW'(i_q)) begin
                slot     = JW'(row_q >> (32'(col) * JW));
                agree    = (spin_q[AW'(col)] == spin_q[i_q]);
                positive = ~(agree ^ slot[JW-1]);
                mag_ext  = E_W'(slot[JW-2:0]);
                lane_sum = positive ? (lane_sum + mag_ext) : (lane_sum - mag_ext);
            end
        end
        acc_sum = acc_q + lane_sum;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath updates and outputs
    always_comb begin
        state_d  = state_q;
        spin_d   = spin_q;
        row_d    = row_q;
        i_d      = i_q;
        c_d      = c_q;
        acc_d    = acc_q;
        energy_d = energy_q;
`ifdef ISING_BEST_TRACK_EN
        best_d        = best_q;
        best_update_d = 1'b0;
`endif
        bus.j_rd_en = (state_q == ST_FETCH);
        bus.j_addr  = i_q;
        bus.busy    = (state_q != ST_IDLE);
        bus.done    = (state_q == ST_FINISH);
        bus.energy  = energy_q;
`ifdef ISING_BEST_TRACK_EN
        bus.best_energy = best_q;
        bus.best_update = best_update_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    spin_d  = bus.spin_vec;
                    acc_d   = '0;
                    i_d     = AW'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                row_d   = bus.j_row_data;
                c_d     = '0;
                state_d = ST_ACC;
            end
            ST_ACC: begin
                acc_d = acc_sum;
                c_d   = c_q + CW'(LANES);
                if ((c_q + CW'(LANES)) >= CW'(i_q)) begin
                    if (i_q == AW'(N_SPIN - 1)) begin
                        // Result and best tracking are registered on entry to FINISH
                        // so they are already valid in the done cycle.
                        energy_d = acc_sum;
`ifdef ISING_BEST_TRACK_EN
                        if (acc_sum < best_q) begin
                            best_d        = acc_sum;
                            best_update_d = 1'b1;
                        end
`endif
                        state_d = ST_FINISH;
                    end else begin
                        i_d     = i_q + AW'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spin_q   <= '0;
            row_q    <= '0;
            i_q      <= '0;
            c_q      <= '0;
            acc_q    <= '0;
            energy_q <= '0;
`ifdef ISING_BEST_TRACK_EN
            best_q        <= {1'b0, {(E_W-1){1'b1}}};
            best_update_q <= 1'b0;
`endif
        end else begin
            spin_q   <= spin_d;
            row_q    <= row_d;
            i_q      <= i_d;
            c_q      <= c_d;
            acc_q    <= acc_d;
            energy_q <= energy_d;
`ifdef ISING_BEST_TRACK_EN
            best_q        <= best_d;
            best_update_q <= best_update_d;
`endif
        end
    end
endmodule

// File: tb/tb_ising_energy_engine.sv
// Directed self-checking bench for ising_energy_engine (N_SPIN=4, JW=4, LANES=2).
// Optional ISING_BEST_TRACK_EN scenarios compile only when the macro is defined.
module tb_ising_energy_engine;
    localparam int N   = 4;
    localparam int JW  = 4;
    localparam int LN  = 2;
    localparam int E_W = 12;
    localparam int LAT = 11;

    typedef struct {
        int                    done_cyc;
        int                    done_cnt;
        int                    rd_cnt;
        logic [3:0]            rd_mask;
        logic                  busy1;
        logic signed [E_W-1:0] e;
        int                    bu_cnt;
        logic                  bu_at_done;
    } run_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [15:0] row_mem [4];

    ising_energy_engine_if #(.N_SPIN(N), .JW(JW), .E_W(E_W)) bus ();

    ising_energy_engine #(.N_SPIN(N), .JW(JW), .LANES(LN), .E_W(E_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Coupling memory: registered read, data valid one cycle after j_rd_en
    always @(posedge clk) begin
        if (bus.j_rd_en) bus.j_row_data <= row_mem[bus.j_addr];
    end

    task automatic fill_uniform(input logic [3:0] c);
        for (int r = 0; r < 4; r++) row_mem[r] = {4{c}};
    endtask

    task automatic fill_mixed();
        row_mem[0] = 16'hFFFF;
        row_mem[1] = 16'hFFF1;
        row_mem[2] = 16'hFF3A;
        row_mem[3] = 16'hFE5C;
    endtask

    // One run starting at the next negedge (cycle 0); observes cycles 1..LAT
    task automatic do_run(input logic [3:0] spins, input bit disturb, output run_t r);
        r.done_cyc = -1; r.done_cnt = 0; r.rd_cnt = 0; r.rd_mask = '0;
        r.busy1 = 1'b0; r.e = '0; r.bu_cnt = 0; r.bu_at_done = 1'b0;
        @(negedge clk);
        bus.spin_vec = spins;
        bus.start = 1'b1;
        for (int n = 1; n <= LAT; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (n == 1) r.busy1 = bus.busy;
            if (bus.j_rd_en) begin
                r.rd_cnt++;
                r.rd_mask[bus.j_addr] = 1'b1;
            end
`ifdef ISING_BEST_TRACK_EN
            if (bus.best_update) r.bu_cnt++;
            if (bus.done) r.bu_at_done = bus.best_update;
`endif
            if (bus.done) begin
                r.done_cnt++;
                if (r.done_cyc < 0) begin
                    r.done_cyc = n;
                    r.e = bus.energy;
                end
            end
            if (disturb) begin
                if (n == 2) bus.spin_vec = 4'b0101;
                if (n == 3 || n == 7) bus.start = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.j_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b want 0", bus.j_rd_en); end
        n_cmp++; if (bus.j_addr !== 2'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", bus.j_addr); end
        n_cmp++; if (bus.energy !== 12'sd0) begin n_bad++; $display("FAIL reset_energy: got %0d want 0", bus.energy); end
`ifdef ISING_BEST_TRACK_EN
        n_cmp++; if (bus.best_energy !== 12'sd2047) begin n_bad++; $display("FAIL reset_best: got %0d want 2047", bus.best_energy); end
        n_cmp++; if (bus.best_update !== 1'b0) begin n_bad++; $display("FAIL reset_best_update: got %b want 0", bus.best_update); end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [3:0]            sp [3];
        logic signed [E_W-1:0] ex [3];
        run_t r;
        sp = '{4'b0000, 4'b0001, 4'b0101};
        ex = '{12'sd18, 12'sd0, -12'sd6};
        fill_uniform(4'b1011);
        for (int t = 0; t < 3; t++) begin
            do_run(sp[t], 1'b0, r);
            n_cmp++; if (r.done_cyc !== LAT) begin n_bad++; $display("FAIL basic_done_cycle[%0d]: got %0d want %0d", t, r.done_cyc, LAT); end
            n_cmp++; if (r.done_cnt !== 1) begin n_bad++; $display("FAIL basic_done_count[%0d]: got %0d want 1", t, r.done_cnt); end
            n_cmp++; if (r.e !== ex[t]) begin n_bad++; $display("FAIL basic_energy[%0d]: got %0d want %0d", t, r.e, ex[t]); end
            n_cmp++; if (r.busy1 !== 1'b1) begin n_bad++; $display("FAIL basic_busy[%0d]: got %b want 1", t, r.busy1); end
            n_cmp++; if (r.rd_cnt !== 3) begin n_bad++; $display("FAIL basic_rd_count[%0d]: got %0d want 3", t, r.rd_cnt); end
            n_cmp++; if (r.rd_mask !== 4'b1110) begin n_bad++; $display("FAIL basic_rd_rows[%0d]: got %b want 1110", t, r.rd_mask); end
        end
        n_cmp++; if (bus.energy !== -12'sd6) begin n_bad++; $display("FAIL basic_energy_hold: got %0d want -6", bus.energy); end
    endtask

    task automatic test_signs();
        logic [3:0]            cp [3];
        logic signed [E_W-1:0] ex [3];
        run_t r;
        cp = '{4'b0010, 4'b1000, 4'b0000};
        ex = '{-12'sd12, 12'sd0, 12'sd0};
        for (int t = 0; t < 3; t++) begin
            fill_uniform(cp[t]);
            do_run(4'b1111, 1'b0, r);
            n_cmp++; if (r.e !== ex[t]) begin n_bad++; $display("FAIL signs_energy[%0d]: got %0d want %0d", t, r.e, ex[t]); end
            n_cmp++; if (r.done_cyc !== LAT) begin n_bad++; $display("FAIL signs_done_cycle[%0d]: got %0d want %0d", t, r.done_cyc, LAT); end
        end
    endtask

    task automatic test_mixed();
        run_t r;
        fill_mixed();
        do_run(4'b0110, 1'b0, r);
        n_cmp++; if (r.e !== -12'sd1) begin n_bad++; $display("FAIL mixed_energy: got %0d want -1", r.e); end
        n_cmp++; if (r.done_cyc !== LAT) begin n_bad++; $display("FAIL mixed_done_cycle: got %0d want %0d", r.done_cyc, LAT); end
    endtask

    task automatic test_back_to_back();
        run_t r;
        fill_uniform(4'b1011);
        do_run(4'b0000, 1'b1, r);
        n_cmp++; if (r.done_cnt !== 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d want 1", r.done_cnt); end
        n_cmp++; if (r.done_cyc !== LAT) begin n_bad++; $display("FAIL ignore_done_cycle: got %0d want %0d", r.done_cyc, LAT); end
        n_cmp++; if (r.e !== 12'sd18) begin n_bad++; $display("FAIL ignore_snapshot_energy: got %0d want 18", r.e); end
        do_run(4'b0101, 1'b0, r);
        n_cmp++; if (r.busy1 !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: got %b want 1", r.busy1); end
        n_cmp++; if (r.done_cyc !== LAT) begin n_bad++; $display("FAIL b2b_done_cycle: got %0d want %0d", r.done_cyc, LAT); end
        n_cmp++; if (r.e !== -12'sd6) begin n_bad++; $display("FAIL b2b_energy: got %0d want -6", r.e); end
    endtask

    task automatic test_reset_midrun();
        run_t r;
        int dcnt;
        int bcnt;
        @(negedge clk);
        bus.spin_vec = 4'b0000;
        bus.start = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL midrun_busy_before: got %b want 1", bus.busy); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrun_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.energy !== 12'sd0) begin n_bad++; $display("FAIL midrun_energy: got %0d want 0", bus.energy); end
        n_cmp++; if (bus.j_rd_en !== 1'b0) begin n_bad++; $display("FAIL midrun_rd_en: got %b want 0", bus.j_rd_en); end
        n_cmp++; if (bus.j_addr !== 2'd0) begin n_bad++; $display("FAIL midrun_addr: got %0d want 0", bus.j_addr); end
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        bcnt = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
            if (bus.busy) bcnt++;
        end
        n_cmp++; if (dcnt !== 0) begin n_bad++; $display("FAIL midrun_no_done: got %0d want 0", dcnt); end
        n_cmp++; if (bcnt !== 0) begin n_bad++; $display("FAIL midrun_stays_idle: got %0d want 0", bcnt); end
        fill_mixed();
        do_run(4'b0110, 1'b0, r);
        n_cmp++; if (r.e !== -12'sd1) begin n_bad++; $display("FAIL midrun_fresh_energy: got %0d want -1", r.e); end
        n_cmp++; if (r.done_cyc !== LAT) begin n_bad++; $display("FAIL midrun_fresh_done_cycle: got %0d want %0d", r.done_cyc, LAT); end
    endtask

    task automatic test_best_track();
`ifdef ISING_BEST_TRACK_EN
        logic [3:0]            cp [3];
        logic [3:0]            sp [3];
        logic signed [E_W-1:0] ex [3];
        int                    bu [3];
        run_t r;
        cp = '{4'b1011, 4'b1011, 4'b1001};
        sp = '{4'b0000, 4'b0001, 4'b0000};
        ex = '{12'sd18, 12'sd0, 12'sd6};
        bu = '{1, 1, 0};
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            fill_uniform(cp[t]);
            do_run(sp[t], 1'b0, r);
            n_cmp++; if (r.e !== ex[t]) begin n_bad++; $display("FAIL best_run_energy[%0d]: got %0d want %0d", t, r.e, ex[t]); end
            n_cmp++; if (r.bu_cnt !== bu[t]) begin n_bad++; $display("FAIL best_update_count[%0d]: got %0d want %0d", t, r.bu_cnt, bu[t]); end
            n_cmp++; if (r.bu_at_done !== (bu[t] == 1)) begin n_bad++; $display("FAIL best_update_with_done[%0d]: got %b want %b", t, r.bu_at_done, bu[t] == 1); end
        end
        n_cmp++; if (bus.best_energy !== 12'sd0) begin n_bad++; $display("FAIL best_energy_final: got %0d want 0", bus.best_energy); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.spin_vec = '0;
        fill_uniform(4'b0000);
        test_reset();
        test_basic();
        test_signs();
        test_mixed();
        test_back_to_back();
        test_reset_midrun();
        test_best_track();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
